// File: rtl/ram_arbiter_if.sv
// ram_arbiter_if: CPU/video requester ports and RAM bus bundled for ram_arbiter.
// master = requesters plus RAM (the arbiter's environment), slave = the arbiter itself.
interface ram_arbiter_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
);
    logic                  cpu_req;
    logic                  cpu_we;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [DATA_WIDTH-1:0] cpu_wdata;
    logic                  cpu_ack;
    logic [DATA_WIDTH-1:0] cpu_rdata;
    logic                  cpu_rvalid;
    logic                  vid_req;
    logic [ADDR_WIDTH-1:0] vid_addr;
    logic                  vid_ack;
    logic [DATA_WIDTH-1:0] vid_rdata;
    logic                  vid_rvalid;
    logic                  ram_cs;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
        input  cpu_ack, cpu_rdata, cpu_rvalid, vid_ack, vid_rdata, vid_rvalid,
        input  ram_cs, ram_we, ram_addr, ram_wdata
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_req, vid_addr, ram_rdata,
        output cpu_ack, cpu_rdata, cpu_rvalid, vid_ack, vid_rdata, vid_rvalid,
        output ram_cs, ram_we, ram_addr, ram_wdata
    );
endinterface

// File: rtl/ram_arbiter.sv
// ram_arbiter: arbitrates a CPU (read/write) and a video fetcher (read-only) onto one synchronous RAM.
// Optional macro RAM_ARB_ROUND_ROBIN_EN: alternate grants on contention; otherwise video always wins.
module ram_arbiter #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_t;

    state_t                state, state_nxt;
    logic                  grant, pick_vid, gnt_vid, gnt_vid_nxt;
    logic                  cs_nxt, we_nxt, cpu_ack_nxt, vid_ack_nxt;
    logic                  cpu_rvalid_nxt, vid_rvalid_nxt;
    logic [ADDR_WIDTH-1:0] addr_nxt;
    logic [DATA_WIDTH-1:0] wdata_nxt, cpu_rdata_nxt, vid_rdata_nxt;

`ifdef RAM_ARB_ROUND_ROBIN_EN
    logic ptr_vid;
    assign pick_vid = bus.vid_req & (~bus.cpu_req | ptr_vid);
`else
    assign pick_vid = bus.vid_req;
`endif
    assign grant = (state == IDLE) & (bus.cpu_req | bus.vid_req);

    // State, priority pointer and all registered outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= IDLE;
            gnt_vid        <= 1'b0;
            bus.ram_cs     <= 1'b0;
            bus.ram_we     <= 1'b0;
            bus.ram_addr   <= '0;
            bus.ram_wdata  <= '0;
            bus.cpu_ack    <= 1'b0;
            bus.vid_ack    <= 1'b0;
            bus.cpu_rvalid <= 1'b0;
            bus.vid_rvalid <= 1'b0;
            bus.cpu_rdata  <= '0;
            bus.vid_rdata  <= '0;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            ptr_vid        <= 1'b1;
`endif
        end else begin
            state          <= state_nxt;
            gnt_vid        <= gnt_vid_nxt;
            bus.ram_cs     <= cs_nxt;
            bus.ram_we     <= we_nxt;
            bus.ram_addr   <= addr_nxt;
            bus.ram_wdata  <= wdata_nxt;
            bus.cpu_ack    <= cpu_ack_nxt;
            bus.vid_ack    <= vid_ack_nxt;
            bus.cpu_rvalid <= cpu_rvalid_nxt;
            bus.vid_rvalid <= vid_rvalid_nxt;
            bus.cpu_rdata  <= cpu_rdata_nxt;
            bus.vid_rdata  <= vid_rdata_nxt;
`ifdef RAM_ARB_ROUND_ROBIN_EN
            if (grant & bus.cpu_req & bus.vid_req)
                ptr_vid <= ~ptr_vid;
`endif
        end
    end

    // Next state: grant leaves IDLE, a read detours through RDATA for the RAM's one-cycle latency
    always_comb begin
        state_nxt = grant ? ACCESS : (state == ACCESS && !bus.ram_we) ? RDATA : IDLE;
    end

    // Next output values: load RAM bus on grant, drop strobes otherwise, capture read data in RDATA
    always_comb begin
        cs_nxt         = grant;
        cpu_ack_nxt    = grant & ~pick_vid;
        vid_ack_nxt    = grant & pick_vid;
        we_nxt         = grant & ~pick_vid & bus.cpu_we;
        addr_nxt       = grant ? (pick_vid ? bus.vid_addr : bus.cpu_addr) : bus.ram_addr;
        wdata_nxt      = (grant & ~pick_vid) ? bus.cpu_wdata : bus.ram_wdata;
        gnt_vid_nxt    = grant ? pick_vid : gnt_vid;
        cpu_rvalid_nxt = (state == RDATA) & ~gnt_vid;
        vid_rvalid_nxt = (state == RDATA) & gnt_vid;
        cpu_rdata_nxt  = cpu_rvalid_nxt ? bus.ram_rdata : bus.cpu_rdata;
        vid_rdata_nxt  = vid_rvalid_nxt ? bus.ram_rdata : bus.vid_rdata;
    end
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_ram_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ram_arbiter_if #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) bus ();

    ram_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        bit          vid;
        bit          we;
        logic [15:0] addr;
        logic [7:0]  wdata;
    } acc_t;

    typedef struct {
        bit         vid;
        logic [7:0] data;
    } rd_t;

    acc_t       acc_q[$];
    rd_t        rd_q[$];
    logic [7:0] mem [0:65535];
    logic [7:0] last_wd = 8'h00;
    logic [7:0] exp_cpu_rd = 8'h00;
    logic [7:0] exp_vid_rd = 8'h00;
    int         n_checks = 0;
    int         n_pass = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    function automatic void push_acc(bit vid, bit we, logic [15:0] addr, logic [7:0] wd);
        acc_t a;
        if (!vid) last_wd = wd;
        a.vid   = vid;
        a.we    = we;
        a.addr  = addr;
        a.wdata = last_wd;
        acc_q.push_back(a);
    endfunction

    function automatic void push_rd(bit vid, logic [7:0] data);
        rd_t r;
        r.vid  = vid;
        r.data = data;
        rd_q.push_back(r);
    endfunction

    // Registered-output RAM model: write on cs&we, read data appears the cycle after cs&!we
    always @(posedge clk) begin
        if (bus.ram_cs) begin
            if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
            else bus.ram_rdata <= mem[bus.ram_addr];
        end
    end

    // Monitor: pops the scoreboard whenever the arbiter presents an ack or an rvalid
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.cpu_ack | bus.vid_ack) begin
                check("ack_exclusive", bus.cpu_ack & bus.vid_ack, 0);
                check("ack_expected", acc_q.size() != 0, 1);
                if (acc_q.size() != 0) begin
                    acc_t a;
                    a = acc_q.pop_front();
                    check("grant_vid", bus.vid_ack, a.vid);
                    check("ram_cs", bus.ram_cs, 1);
                    check("ram_we", bus.ram_we, a.we);
                    check("ram_addr", bus.ram_addr, a.addr);
                    check("ram_wdata", bus.ram_wdata, a.wdata);
                end
            end
            if (bus.cpu_rvalid | bus.vid_rvalid) begin
                check("rvalid_exclusive", bus.cpu_rvalid & bus.vid_rvalid, 0);
                check("rvalid_expected", rd_q.size() != 0, 1);
                if (rd_q.size() != 0) begin
                    rd_t r;
                    r = rd_q.pop_front();
                    check("rvalid_vid", bus.vid_rvalid, r.vid);
                    if (r.vid) exp_vid_rd = r.data;
                    else exp_cpu_rd = r.data;
                    check("cpu_rdata", bus.cpu_rdata, exp_cpu_rd);
                    check("vid_rdata", bus.vid_rdata, exp_vid_rd);
                end
            end
        end
    end

    function automatic logic [63:0] all_outputs();
        return {bus.cpu_ack, bus.cpu_rdata, bus.cpu_rvalid, bus.vid_ack, bus.vid_rdata,
                bus.vid_rvalid, bus.ram_cs, bus.ram_we, bus.ram_addr, bus.ram_wdata};
    endfunction

    // Single uncontested access; checks ack latency 1 and (reads) rvalid latency 3 from the sample edge
    task automatic do_access(input bit vid, input bit we, input logic [15:0] addr,
                             input logic [7:0] wd, input logic [7:0] rd);
        int n;
        push_acc(vid, we, addr, wd);
        if (!we) push_rd(vid, rd);
        if (vid) begin
            bus.vid_req  = 1'b1;
            bus.vid_addr = addr;
        end else begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = we;
            bus.cpu_addr  = addr;
            bus.cpu_wdata = wd;
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(vid ? bus.vid_ack : bus.cpu_ack) && n < 20);
        check("ack_latency", n, 1);
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        if (!we) begin
            do begin
                @(negedge clk);
                n++;
            end while (!(vid ? bus.vid_rvalid : bus.cpu_rvalid) && n < 20);
            check("rvalid_latency", n, 3);
        end
        @(negedge clk);
    endtask

    initial begin
        int n, k, last;
        bit seq [4];
        mem[16'h8000] = 8'h3C;
        mem[16'h0010] = 8'h77;
        mem[16'h1234] = 8'h00;
        bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
        bus.vid_req = 1'b0; bus.vid_addr = '0; bus.ram_rdata = '0;

        // Reset and ten quiet cycles
        repeat (3) @(negedge clk);
        check("reset_outputs", all_outputs(), 0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_outputs", all_outputs(), 0);
        end

        // CPU write then read-back of 0x1234
        do_access(0, 1, 16'h1234, 8'hA5, 8'h00);
        do_access(0, 0, 16'h1234, 8'h00, 8'hA5);

        // Video read leaves CPU outputs alone
        do_access(1, 0, 16'h8000, 8'h00, 8'h3C);

        // Contention: both requesters held high for four grants
`ifdef RAM_ARB_ROUND_ROBIN_EN
        seq = '{1, 0, 1, 0};
`else
        seq = '{1, 1, 1, 1};
`endif
        for (int i = 0; i < 4; i++) begin
            push_acc(seq[i], 0, seq[i] ? 16'h8000 : 16'h1234, 8'h5A);
            push_rd(seq[i], seq[i] ? 8'h3C : 8'hA5);
        end
`ifndef RAM_ARB_ROUND_ROBIN_EN
        push_acc(0, 0, 16'h1234, 8'h5A);
        push_rd(0, 8'hA5);
`endif
        bus.vid_req = 1'b1; bus.vid_addr = 16'h8000;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h1234; bus.cpu_wdata = 8'h5A;
        k = 0;
        n = 0;
        while (k < 4 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.cpu_ack | bus.vid_ack) k++;
        end
        check("contended_grants", k, 4);
        bus.vid_req = 1'b0;
`ifndef RAM_ARB_ROUND_ROBIN_EN
        n = 0;
        while (!bus.cpu_ack && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("starved_cpu_granted", bus.cpu_ack, 1);
`endif
        bus.cpu_req = 1'b0;
        n = 0;
        while (rd_q.size() != 0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("contended_drain", rd_q.size(), 0);
        @(negedge clk);

        // Reset during RDATA of a CPU read of 0x0010 aborts it
        push_acc(0, 0, 16'h0010, 8'h00);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 16'h0010; bus.cpu_wdata = 8'h00;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cpu_ack && n < 20);
        check("abort_ack_latency", n, 1);
        bus.cpu_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("abort_outputs", all_outputs(), 0);
        exp_cpu_rd = 8'h00;
        exp_vid_rd = 8'h00;
        last_wd = 8'h00;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_rvalid", all_outputs(), 0);
        end

        // Back-to-back CPU writes 0x0000..0x0003
        for (int i = 0; i < 4; i++) push_acc(0, 1, 16'(i), 8'(8'h10 + i));
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 16'h0000; bus.cpu_wdata = 8'h10;
        k = 0;
        n = 0;
        last = 0;
        while (k < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.cpu_ack) begin
                if (k > 0) check("b2b_ack_spacing", n - last, 2);
                last = n;
                k++;
                if (k < 4) begin
                    bus.cpu_addr  = 16'(k);
                    bus.cpu_wdata = 8'(8'h10 + k);
                end else bus.cpu_req = 1'b0;
            end else if (k > 0) check("b2b_cs_gap", bus.ram_cs, 0);
        end
        check("b2b_acks", k, 4);
        @(negedge clk);
        do_access(0, 0, 16'h0003, 8'h00, 8'h13);

        repeat (4) @(negedge clk);
        check("acc_queue_empty", acc_q.size(), 0);
        check("rd_queue_empty", rd_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/ram_arbiter.md
RAM_ARBITER -- requirements
Module: ram_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 16, RAM address width in bits.
REQ-002 Parameter DATA_WIDTH, default 8, RAM data width in bits.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 cpu_req  input  1  CPU access request; held high until cpu_ack.
REQ-006 cpu_we  input  1  CPU access type: 1 write, 0 read.
REQ-007 cpu_addr  input  ADDR_WIDTH  CPU address.
REQ-008 cpu_wdata  input  DATA_WIDTH  CPU write data.
REQ-009 cpu_ack  output  1  one-cycle pulse: CPU request granted and issued.
REQ-010 cpu_rdata  output  DATA_WIDTH  CPU read data; holds last read value.
REQ-011 cpu_rvalid  output  1  one-cycle pulse: cpu_rdata updated.
REQ-012 vid_req  input  1  video fetch request, read-only; held high until vid_ack.
REQ-013 vid_addr  input  ADDR_WIDTH  video fetch address.
REQ-014 vid_ack, vid_rdata, vid_rvalid  output  1/DATA_WIDTH/1  video equivalents of REQ-009..011.
REQ-015 ram_cs, ram_we  output  1 each  RAM chip select, write enable.
REQ-016 ram_addr, ram_wdata  output  ADDR_WIDTH/DATA_WIDTH  RAM address, write data.
REQ-017 ram_rdata  input  DATA_WIDTH  RAM read data; valid cycle after a read ram_cs (1-cycle registered latency).

Function
REQ-018 FSM states IDLE, ACCESS, RDATA; all outputs registered.
REQ-019 IDLE: if any req high at rising edge, grant one requester, load ram_addr/ram_we/ram_wdata from it, set ram_cs=1 and its ack=1, go ACCESS; else stay IDLE, ram_cs=0.
REQ-020 ACCESS: exactly one cycle; ram_cs and ack high; next state RDATA if read, IDLE if write; ram_cs, ram_we, ack cleared on exit.
REQ-021 RDATA: at end of cycle, granted requester's rdata <= ram_rdata, its rvalid=1 for following cycle; next state IDLE.
REQ-022 Video accesses always reads; ram_we=0, ram_wdata unchanged.
REQ-023 Latency from req sampled: write ram_cs cycle+1; read rvalid cycle+3; back-to-back throughput 2 cycles/write, 3 cycles/read.
REQ-024 Requester inputs sampled only at grant edge; req high during its ack cycle is ignored, re-evaluated next IDLE.
REQ-025 Never both acks, never both rvalids in one cycle; rvalid of one may coincide with ack of the other.
REQ-026 No address/data width conversion; ram_addr/ram_wdata passed bit-exact.

Reset
REQ-027 rst_n=0 at rising edge: state IDLE; ram_cs, ram_we, acks, rvalids = 0; ram_addr, ram_wdata, cpu_rdata, vid_rdata = 0; priority pointer = video.
REQ-028 Reset mid-ACCESS or mid-RDATA aborts access; pending rvalid never asserted.

Configuration
REQ-029 Macro RAM_ARB_ROUND_ROBIN_EN defined: simultaneous requests in IDLE alternate grant, pointer toggles after each contested grant, first contested grant to video.
REQ-030 Macro undefined: video always wins simultaneous requests (fixed priority); no pointer state.

Verification
REQ-031 Reset, no reqs -> all outputs 0 for 10 cycles.
REQ-032 cpu_req write addr=0x1234 data=0xA5 -> ram_cs=ram_we=1, ram_addr=0x1234, ram_wdata=0xA5, cpu_ack one cycle after sample; later read 0x1234 -> cpu_rdata=0xA5, cpu_rvalid 3 cycles after sample.
REQ-033 vid_req read 0x8000 (RAM holds 0x3C) -> vid_rdata=0x3C, vid_rvalid pulse; cpu outputs unchanged.
REQ-034 cpu_req and vid_req both high, 4 grants -> without macro: V,V,V,V (cpu starved while vid held); with RAM_ARB_ROUND_ROBIN_EN: V,C,V,C.
REQ-035 rst_n low during RDATA of read 0x0010 -> no rvalid, rdata 0, FSM IDLE next cycle.
REQ-036 Back-to-back CPU writes 0x0000..0x0003 -> ram_cs pulses every 2 cycles, four acks, no overlap.
